// File: rtl/psg_stereo_mixer.sv
// psg_stereo_mixer
// Mixes the three PSG channel levels into a stereo pair (ABC / ACB / mono),
// averages 2^DECIM_LOG2 consecutive samples into each output word, and hands
// the 16-bit L/R words to the audio path over a valid/ready handshake.
//
// Optional build macro PSG_DC_FILTER_EN: inserts a per-channel DC-blocking
// stage between the averager and the output register. The output words then
// become signed, and latency grows by one CLK.
module psg_stereo_mixer #(
    parameter int DECIM_LOG2 = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic [7:0]  CHANNEL_A,
    input  logic [7:0]  CHANNEL_B,
    input  logic [7:0]  CHANNEL_C,
    input  logic [1:0]  STEREO_MODE,
    input  logic        MUTE,
    output logic [15:0] OUT_L,
    output logic [15:0] OUT_R,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OVERRUN
);

    // Accumulator width chosen so that 2^DECIM_LOG2 samples of at most 765
    // can never overflow.
    localparam int ACC_W = 10 + DECIM_LOG2;
    // The counter needs at least one bit even when every CE produces a word.
    localparam int CNT_W = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << DECIM_LOG2) - 1);

    logic [9:0]       w_mix_l;
    logic [9:0]       w_mix_r;
    logic [ACC_W-1:0] r_acc_l;
    logic [ACC_W-1:0] r_acc_r;
    logic [ACC_W-1:0] w_sum_l;
    logic [ACC_W-1:0] w_sum_r;
    logic [9:0]       w_avg_l;
    logic [9:0]       w_avg_r;
    logic [CNT_W-1:0] r_cnt;
    logic             w_final;

    logic             w_load;
    logic [15:0]      w_word_l;
    logic [15:0]      w_word_r;

    logic [15:0]      r_out_l;
    logic [15:0]      r_out_r;
    logic             r_valid;
    logic             r_overrun;

    // Panning matrix: pick the per-channel mix for the current sample.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_mix_l = '0;
        w_mix_r = '0;
        if (!MUTE) begin
            case (STEREO_MODE)
                2'b00: begin
                    w_mix_l = {1'b0, CHANNEL_A, 1'b0} + {2'b00, CHANNEL_B};
                    w_mix_r = {1'b0, CHANNEL_C, 1'b0} + {2'b00, CHANNEL_B};
                end
                2'b01: begin
                    w_mix_l = {1'b0, CHANNEL_A, 1'b0} + {2'b00, CHANNEL_C};
                    w_mix_r = {1'b0, CHANNEL_B, 1'b0} + {2'b00, CHANNEL_C};
                end
                default: begin
                    w_mix_l = {2'b00, CHANNEL_A} + {2'b00, CHANNEL_B} + {2'b00, CHANNEL_C};
                    w_mix_r = w_mix_l;
                end
            endcase
        end
    end

    assign w_final = (r_cnt == CNT_MAX);
    assign w_sum_l = r_acc_l + ACC_W'(w_mix_l);
    assign w_sum_r = r_acc_r + ACC_W'(w_mix_r);
    // Dividing by 2^DECIM_LOG2 is just dropping the low bits of the sum.
    assign w_avg_l = w_sum_l[ACC_W-1:DECIM_LOG2];
    assign w_avg_r = w_sum_r[ACC_W-1:DECIM_LOG2];

    // Box averager: accumulate each CE sample, restart after the final one.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt   <= '0;
            r_acc_l <= '0;
            r_acc_r <= '0;
        end else if (CE) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (w_final) begin
                r_cnt   <= '0;
                r_acc_l <= '0;
                r_acc_r <= '0;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_acc_l <= w_sum_l;
                r_acc_r <= w_sum_r;
            end
        end
    end

`ifdef PSG_DC_FILTER_EN
    logic               r_stg_v;
    logic [9:0]         r_stg_l;
    logic [9:0]         r_stg_r;
    logic signed [23:0] r_dc_l;
    logic signed [23:0] r_dc_r;
    logic [17:0]        w_y_l;
    logic [17:0]        w_y_r;

    // Saturate an 18-bit two's-complement value into signed 16 bits.
    function automatic logic [15:0] sat16(input logic [17:0] v);
        if (v[17:15] == 3'b000 || v[17:15] == 3'b111) begin
            return v[15:0];
        end
        return v[17] ? 16'h8000 : 16'h7FFF;
    endfunction

    // Pipeline register between averager and DC blocker.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stg_v <= 1'b0;
            r_stg_l <= '0;
            r_stg_r <= '0;
        end else begin
            r_stg_v <= CE && w_final;
            if (CE && w_final) begin
                r_stg_l <= w_avg_l;
                r_stg_r <= w_avg_r;
            end
        end
    end

    // y = x - dc with x = {avg, 6'b0} (positive) and dc = dc_acc[23:8].
    assign w_y_l = {2'b00, r_stg_l, 6'b0} - {{2{r_dc_l[23]}}, r_dc_l[23:8]};
    assign w_y_r = {2'b00, r_stg_r, 6'b0} - {{2{r_dc_r[23]}}, r_dc_r[23:8]};

    // DC estimate leaks toward the signal by 1/256 of the error per word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_dc_l <= '0;
            r_dc_r <= '0;
        end else if (r_stg_v) begin
            r_dc_l <= r_dc_l + {{6{w_y_l[17]}}, w_y_l};
            r_dc_r <= r_dc_r + {{6{w_y_r[17]}}, w_y_r};
        end
    end

    assign w_load   = r_stg_v;
    assign w_word_l = sat16(w_y_l);
    assign w_word_r = sat16(w_y_r);
`else
    assign w_load   = CE && w_final;
    assign w_word_l = {w_avg_l, 6'b0};
    assign w_word_r = {w_avg_r, 6'b0};
`endif

    // Output register and handshake; a load at the same edge as an accept wins.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_l   <= '0;
            r_out_r   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_load) begin
            r_out_l <= w_word_l;
            r_out_r <= w_word_r;
            r_valid <= 1'b1;
            if (r_valid && !OUT_READY) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && OUT_READY) begin
            r_valid <= 1'b0;
        end
    end

    assign OUT_L     = r_out_l;
    assign OUT_R     = r_out_r;
    assign OUT_VALID = r_valid;
    assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// Directed bench for psg_stereo_mixer with DECIM_LOG2=3.
// Default build checks the plain averager; with PSG_DC_FILTER_EN defined it
// checks the DC-blocking path instead.
module tb_psg_stereo_mixer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CE;
    logic [7:0]  CHANNEL_A;
    logic [7:0]  CHANNEL_B;
    logic [7:0]  CHANNEL_C;
    logic [1:0]  STEREO_MODE;
    logic        MUTE;
    logic [15:0] OUT_L;
    logic [15:0] OUT_R;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OVERRUN;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic        mute;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  c;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs[7];

    psg_stereo_mixer #(.DECIM_LOG2(3)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .CE(CE),
        .CHANNEL_A(CHANNEL_A),
        .CHANNEL_B(CHANNEL_B),
        .CHANNEL_C(CHANNEL_C),
        .STEREO_MODE(STEREO_MODE),
        .MUTE(MUTE),
        .OUT_L(OUT_L),
        .OUT_R(OUT_R),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ce_burst(input int n);
        CE = 1'b1;
        repeat (n) tick();
        CE = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic set_in(input logic [1:0] mode, input logic mute,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        STEREO_MODE = mode;
        MUTE        = mute;
        CHANNEL_A   = a;
        CHANNEL_B   = b;
        CHANNEL_C   = c;
    endtask

    initial begin
        vecs[0] = '{"abc_const",  2'b00, 1'b0, 8'h10, 8'h20, 8'h30, 16'h1000, 16'h2000};
        vecs[1] = '{"mono_const", 2'b10, 1'b0, 8'h10, 8'h20, 8'h30, 16'h1800, 16'h1800};
        vecs[2] = '{"acb_max",    2'b01, 1'b0, 8'hFF, 8'hFF, 8'hFF, 16'hBF40, 16'hBF40};
        vecs[3] = '{"mute",       2'b01, 1'b1, 8'hFF, 8'hFF, 8'hFF, 16'h0000, 16'h0000};
        vecs[4] = '{"abc_mixed",  2'b00, 1'b0, 8'h40, 8'h01, 8'h80, 16'h2040, 16'h4040};
        vecs[5] = '{"acb_small",  2'b01, 1'b0, 8'h01, 8'h02, 8'h03, 16'h0140, 16'h01C0};
        vecs[6] = '{"mono_edge",  2'b11, 1'b0, 8'hFF, 8'h00, 8'h01, 16'h4000, 16'h4000};

        CE        = 1'b0;
        OUT_READY = 1'b1;
        set_in(2'b00, 1'b0, 8'h00, 8'h00, 8'h00);
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        check("reset_out_l",   32'(OUT_L), 32'h0);
        check("reset_out_r",   32'(OUT_R), 32'h0);
        check("reset_valid",   32'(OUT_VALID), 32'h0);
        check("reset_overrun", 32'(OVERRUN), 32'h0);

`ifndef PSG_DC_FILTER_EN
        // Table: 8 constant samples per word, READY held high.
        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].mode, vecs[i].mute, vecs[i].a, vecs[i].b, vecs[i].c);
            ce_burst(7);
            check({vecs[i].name, "_valid_early"}, 32'(OUT_VALID), 32'h0);
            ce_burst(1);
            check({vecs[i].name, "_valid"},   32'(OUT_VALID), 32'h1);
            check({vecs[i].name, "_l"},       32'(OUT_L), 32'(vecs[i].exp_l));
            check({vecs[i].name, "_r"},       32'(OUT_R), 32'(vecs[i].exp_r));
            tick();
            check({vecs[i].name, "_valid_1cyc"}, 32'(OUT_VALID), 32'h0);
            check({vecs[i].name, "_overrun"}, 32'(OVERRUN), 32'h0);
        end

        // A alternates 0x00/0xFF each CE: average of 0 and 510 is 255.
        set_in(2'b00, 1'b0, 8'h00, 8'h00, 8'h00);
        CE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            CHANNEL_A = (i % 2 == 1) ? 8'hFF : 8'h00;
            tick();
        end
        CE = 1'b0;
        check("alt_valid", 32'(OUT_VALID), 32'h1);
        check("alt_l",     32'(OUT_L), 32'h3FC0);
        check("alt_r",     32'(OUT_R), 32'h0000);
        tick();

        // Two words with READY low: the second overwrites and flags overrun.
        OUT_READY = 1'b0;
        set_in(2'b10, 1'b0, 8'h10, 8'h20, 8'h30);
        ce_burst(8);
        check("ovr_first_valid",   32'(OUT_VALID), 32'h1);
        check("ovr_first_l",       32'(OUT_L), 32'h1800);
        check("ovr_first_overrun", 32'(OVERRUN), 32'h0);
        tick();
        tick();
        check("ovr_hold_valid", 32'(OUT_VALID), 32'h1);
        check("ovr_hold_l",     32'(OUT_L), 32'h1800);
        set_in(2'b00, 1'b0, 8'h10, 8'h20, 8'h30);
        ce_burst(8);
        check("ovr_second_overrun", 32'(OVERRUN), 32'h1);
        check("ovr_second_valid",   32'(OUT_VALID), 32'h1);
        check("ovr_second_l",       32'(OUT_L), 32'h1000);
        check("ovr_second_r",       32'(OUT_R), 32'h2000);
        OUT_READY = 1'b1;
        tick();
        check("ovr_accept_valid",   32'(OUT_VALID), 32'h0);
        check("ovr_accept_overrun", 32'(OVERRUN), 32'h1);
        tick();
        tick();
        check("ovr_sticky", 32'(OVERRUN), 32'h1);

        // Partial sum discarded by reset; RESET overrides CE in its cycle.
        set_in(2'b00, 1'b0, 8'hFF, 8'h00, 8'h00);
        ce_burst(5);
        CE    = 1'b1;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        CE    = 1'b0;
        check("rst_overrun_clear", 32'(OVERRUN), 32'h0);
        check("rst_valid_clear",   32'(OUT_VALID), 32'h0);
        set_in(2'b00, 1'b0, 8'h00, 8'h00, 8'h00);
        ce_burst(7);
        check("rst_cnt_restart", 32'(OUT_VALID), 32'h0);
        ce_burst(1);
        check("rst_word_valid", 32'(OUT_VALID), 32'h1);
        check("rst_word_l",     32'(OUT_L), 32'h0000);
        check("rst_word_r",     32'(OUT_R), 32'h0000);
        check("rst_overrun",    32'(OVERRUN), 32'h0);
        tick();
`else
        begin
            int          words;
            int          viol;
            logic signed [15:0] prev;
            logic signed [15:0] cur;
            int          mag;

            // Constant mono 0x80: x = 384<<6 = 24576, then decays by ~1/256 per word.
            set_in(2'b10, 1'b0, 8'h80, 8'h80, 8'h80);
            CE = 1'b1;
            repeat (8) tick();
            check("dc_latency_early", 32'(OUT_VALID), 32'h0);
            tick();
            check("dc_first_valid", 32'(OUT_VALID), 32'h1);
            check("dc_first_l",     32'(OUT_L), 32'h6000);
            check("dc_first_r",     32'(OUT_R), 32'h6000);
            words = 1;
            viol  = 0;
            prev  = 16'sh6000;
            for (int cyc = 0; cyc < 12000 && words < 1200; cyc++) begin
                tick();
                if (OUT_VALID) begin
                    words++;
                    cur = $signed(OUT_L);
                    if (cur > prev) viol++;
                    prev = cur;
                end
            end
            CE = 1'b0;
            mag = (prev < 0) ? -int'(prev) : int'(prev);
            check("dc_word_count", 32'(words), 32'd1200);
            check("dc_monotonic",  32'(viol), 32'd0);
            check("dc_decayed",    32'(mag < 512), 32'd1);
            do_reset();
            check("dc_reset_valid", 32'(OUT_VALID), 32'h0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
